y86_mem_stage_wait: RTL and testbench
=====================================

# y86_mem_stage_wait

Parametrised Y86-64 pipeline memory stage with a configurable-latency data memory, a wait-state FSM, and a stall/bubble-capable M→W pipeline register. The block sits between the execute-stage M register and write-back. It performs loads for mrmovq, popq and ret, and stores for rmmovq, pushq and call. It raises `mem_busy` so the hazard unit holds F/D/E/M while an access is in flight, and flags out-of-range addresses as ADR.

## Interface
- `ADDR_W`, default 8: word-address width; memory holds 2^ADDR_W words.
- `DATA_W`, default 64: word width.
- `MEM_LAT`, default 2: extra access cycles, legal range 0..7; 0 gives a single-cycle access.
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `M_stat` in 4: stage status (one-hot).
- `M_icode` in 4: instruction code.
- `M_Cnd` in 1: condition flag, passed through unused.
- `M_valE` in DATA_W: ALU result; address for mrmovq, rmmovq, pushq and call.
- `M_valA` in DATA_W: store data, and load address for popq and ret.
- `M_destE`, `M_destM` in 4: destination registers.
- `W_stall` in 1: hold the W register and freeze the FSM.
- `W_bubble` in 1: load a bubble into W.
- `m_stat` out 4: memory-stage status.
- `m_valM` out DATA_W: load data.
- `mem_busy` out 1: stall request to the hazard unit.
- `W_stat`, `W_icode`, `W_valE`, `W_valM`, `W_destE`, `W_destM` out: W pipeline register.

## Operation
- Status codes: AOK=4'b1000, HLT=4'b0100, ADR=4'b0010, INS=4'b0001. Bubble values: icode NOP=4'h1, register RNONE=4'hF.
- Read ops:
  - mrmovq(5) uses address M_valE.
  - popq(B) and ret(9) use address M_valA.
- Write ops: rmmovq(4), pushq(A) and call(8) write M_valA to address M_valE.
- Memory word index is address[ADDR_W-1:0].
- Range check: an address ≥ 2^ADDR_W is out of range. The full DATA_W value is compared unsigned.
- `access` = (M_stat==AOK) && (memory op) && (address in range).
- Out-of-range memory op:
  - m_stat=ADR, no read, no write, no wait.
  - m_valM=0 and mem_busy=0.
- In all other cases m_stat=M_stat.
- FSM states are IDLE, WAIT and DONE, with a 3-bit `cnt`.
  - IDLE: if access && MEM_LAT>0, go to WAIT with cnt=MEM_LAT-1. With MEM_LAT=0, complete in this cycle.
  - WAIT: decrement cnt; at cnt==0 go to DONE.
  - DONE: the access completes this cycle; return to IDLE.
- mem_busy = access && (state!=DONE) && MEM_LAT>0. It is combinational and never asserted when MEM_LAT=0.
- Completion cycle (DONE, or IDLE when MEM_LAT=0) with W_stall=0:
  - a read drives m_valM;
  - a write commits exactly once, at the clock edge;
  - W captures the stage.
- m_valM is 0 outside a read completion cycle.
- W register update priority:
  1. W_stall: hold.
  2. W_bubble, or mem_busy: bubble (stat=AOK, icode=NOP, valE=valM=0, destE=destM=RNONE).
  3. Otherwise load {m_stat, M_icode, M_valE, m_valM, M_destE, M_destM}.
- W_stall freezes the FSM and cnt and suppresses the write commit.
- M inputs are held stable by the hazard unit while mem_busy=1. A change during WAIT is a protocol violation and is checked by an assertion.
- Write-then-read to the same word in consecutive instructions returns the new data.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=IDLE, cnt=0.
  - W_stat=AOK, W_icode=NOP, W_valE=W_valM=0, W_destE=W_destM=RNONE.
  - Memory contents are not reset.
- Reset mid-WAIT aborts the access with no write; after release the FSM is in IDLE.
- Latency: a memory op occupies M for MEM_LAT+1 cycles and asserts mem_busy for MEM_LAT cycles. W receives the result on the edge ending the DONE cycle.
- Non-memory ops and ADR cases: single cycle, no stall.
- Reads are asynchronous from the array; writes are synchronous.

## Structure
- `y86_pkg` holds the icode constants, status codes, RNONE, NOP and the FSM state enum. These are shared with the fetch, decode and execute stages.
- Sub-module `y86_dmem_array` holds DEPTH=2^ADDR_W words of DATA_W, with an asynchronous read port and a synchronous write port gated by `we`.
- The FSM, range check and W register live in the top level.

## Test plan
- MEM_LAT=2: rmmovq with valE=8, valA=0x1234, then mrmovq with valE=8.
  - Each op gives mem_busy high for 2 cycles.
  - W_valM=0x1234 for the mrmovq.
  - Word 8 is written exactly once.
- MEM_LAT=0: pushq with valE=16, valA=0xAA, then popq with valA=16.
  - mem_busy never asserts.
  - W_valM=0xAA one cycle after popq enters M.
- mrmovq with valE=300 (ADDR_W=8): m_stat=ADR, no stall, W_stat=ADR, memory unchanged.
- MEM_LAT=3 with W_stall asserted during DONE: the FSM holds, no write occurs, and the write commits once after W_stall drops.
- rst_n pulsed low during WAIT of a call:
  - W fields return to bubble values immediately.
  - The target word is unchanged.
  - The FSM is in IDLE.
- M_stat=HLT with icode rmmovq: no write, m_stat=HLT, mem_busy=0.

Source files
------------

// File: rtl/y86_pkg.sv
// y86_pkg: icodes, status codes, bubble values and memory-stage FSM states shared across the Y86-64 pipeline
package y86_pkg;
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] S_AOK = 4'b1000;
  localparam logic [3:0] S_HLT = 4'b0100;
  localparam logic [3:0] S_ADR = 4'b0010;
  localparam logic [3:0] S_INS = 4'b0001;
  localparam logic [3:0] RNONE = 4'hF;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} mstate_t;
  function automatic logic is_load(input logic [3:0] ic);
    return ic == I_MRMOVQ || ic == I_POPQ || ic == I_RET;
  endfunction
  function automatic logic is_store(input logic [3:0] ic);
    return ic == I_RMMOVQ || ic == I_PUSHQ || ic == I_CALL;
  endfunction
  function automatic logic addr_from_vala(input logic [3:0] ic);
    return ic == I_POPQ || ic == I_RET;
  endfunction
endpackage

// File: rtl/y86_dmem_array.sv
// y86_dmem_array: data memory with asynchronous read and synchronous gated write
module y86_dmem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] mem [DEPTH];
  // commit a store on the clock edge when enabled; contents are never reset
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/y86_mem_stage_wait.sv
// y86_mem_stage_wait: Y86-64 memory stage with wait-state FSM, ADR range check and stallable M->W register
module y86_mem_stage_wait import y86_pkg::*; #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        M_stat,
  input  logic [3:0]        M_icode,
  input  logic              M_Cnd,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [DATA_W-1:0] M_valA,
  input  logic [3:0]        M_destE,
  input  logic [3:0]        M_destM,
  input  logic              W_stall,
  input  logic              W_bubble,
  output logic [3:0]        m_stat,
  output logic [DATA_W-1:0] m_valM,
  output logic              mem_busy,
  output logic [3:0]        W_stat,
  output logic [3:0]        W_icode,
  output logic [DATA_W-1:0] W_valE,
  output logic [DATA_W-1:0] W_valM,
  output logic [3:0]        W_destE,
  output logic [3:0]        W_destM
);
  mstate_t           state;
  logic [2:0]        cnt;
  logic              rd, wr, in_range, access, done, we, bub, cnd_unused;
  logic [DATA_W-1:0] addr, rdata;
  assign cnd_unused = M_Cnd;
  // decode the access, check the range and derive completion, stall and write strobes
  always_comb begin
    rd       = is_load(M_icode);
    wr       = is_store(M_icode);
    addr     = addr_from_vala(M_icode) ? M_valA : M_valE;
    in_range = (addr >> ADDR_W) == '0;
    access   = M_stat == S_AOK && (rd || wr) && in_range;
    done     = access && (MEM_LAT == 0 || state == DONE);
    mem_busy = access && state != DONE && MEM_LAT != 0;
    we       = done && wr && !W_stall;
    bub      = W_bubble || mem_busy;
    m_stat   = (rd || wr) && !in_range ? S_ADR : M_stat;
    m_valM   = done && rd ? rdata : '0;
  end
  y86_dmem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
    .clk  (clk),
    .we   (we),
    .addr (addr[ADDR_W-1:0]),
    .wdata(M_valA),
    .rdata(rdata)
  );
  // wait-state sequencer: MEM_LAT-1 WAIT cycles between the issue cycle and DONE, frozen by W_stall
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (!W_stall)
      case (state)
        IDLE: if (access && MEM_LAT != 0) begin
          state <= MEM_LAT == 1 ? DONE : WAIT;
          cnt   <= 3'(MEM_LAT - 1);
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt <= 3'd1) state <= DONE;
        end
        default: state <= IDLE;
      endcase
  // M->W register: stall holds, bubble or in-flight access inserts a NOP, otherwise capture the stage
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      W_stat  <= S_AOK;
      W_icode <= I_NOP;
      W_valE  <= '0;
      W_valM  <= '0;
      W_destE <= RNONE;
      W_destM <= RNONE;
    end else if (!W_stall) begin
      W_stat  <= bub ? S_AOK : m_stat;
      W_icode <= bub ? I_NOP : M_icode;
      W_valE  <= bub ? '0 : M_valE;
      W_valM  <= bub ? '0 : m_valM;
      W_destE <= bub ? RNONE : M_destE;
      W_destM <= bub ? RNONE : M_destM;
    end
  // the hazard unit must hold the M register steady while an access is waiting
  m_hold_a: assert property (@(posedge clk) disable iff (!rst_n)
    state == WAIT |-> $stable({M_stat, M_icode, M_valE, M_valA}));
endmodule

// File: tb/tb_y86_mem_stage_wait.sv
// tb_y86_mem_stage_wait: three latencies (0, 2, 3) checked against a per-instruction reference model
module tb_y86_mem_stage_wait;
  import y86_pkg::*;
  localparam int AW = 8;
  localparam int DW = 64;
  localparam logic [143:0] WBUB = {S_AOK, I_NOP, 64'd0, 64'd0, RNONE, RNONE};

  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;

  logic [3:0]    st[3], ic[3], de[3], dm[3], ms[3], wst[3], wic[3], wde[3], wdm[3];
  logic [DW-1:0] ve[3], va[3], mv[3], wve[3], wvm[3];
  logic          cn[3], ws[3], wb[3], busy[3];
  int total = 0, bad = 0, wc0 = 0, wc1 = 0, wc2 = 0;
  logic [DW-1:0] mdl[3][256];
  logic [143:0]  ew[3];

  y86_mem_stage_wait #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .M_stat(st[0]), .M_icode(ic[0]), .M_Cnd(cn[0]), .M_valE(ve[0]),
    .M_valA(va[0]), .M_destE(de[0]), .M_destM(dm[0]), .W_stall(ws[0]), .W_bubble(wb[0]),
    .m_stat(ms[0]), .m_valM(mv[0]), .mem_busy(busy[0]), .W_stat(wst[0]), .W_icode(wic[0]),
    .W_valE(wve[0]), .W_valM(wvm[0]), .W_destE(wde[0]), .W_destM(wdm[0]));
  y86_mem_stage_wait #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2)) u1 (
    .clk(clk), .rst_n(rst_n), .M_stat(st[1]), .M_icode(ic[1]), .M_Cnd(cn[1]), .M_valE(ve[1]),
    .M_valA(va[1]), .M_destE(de[1]), .M_destM(dm[1]), .W_stall(ws[1]), .W_bubble(wb[1]),
    .m_stat(ms[1]), .m_valM(mv[1]), .mem_busy(busy[1]), .W_stat(wst[1]), .W_icode(wic[1]),
    .W_valE(wve[1]), .W_valM(wvm[1]), .W_destE(wde[1]), .W_destM(wdm[1]));
  y86_mem_stage_wait #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) u2 (
    .clk(clk), .rst_n(rst_n), .M_stat(st[2]), .M_icode(ic[2]), .M_Cnd(cn[2]), .M_valE(ve[2]),
    .M_valA(va[2]), .M_destE(de[2]), .M_destM(dm[2]), .W_stall(ws[2]), .W_bubble(wb[2]),
    .m_stat(ms[2]), .m_valM(mv[2]), .mem_busy(busy[2]), .W_stat(wst[2]), .W_icode(wic[2]),
    .W_valE(wve[2]), .W_valM(wvm[2]), .W_destE(wde[2]), .W_destM(wdm[2]));

  always @(posedge clk) if (u0.we) wc0++;
  always @(posedge clk) if (u1.we) wc1++;
  always @(posedge clk) if (u2.we) wc2++;

  function automatic int lat(input int d);
    return d == 0 ? 0 : d == 1 ? 2 : 3;
  endfunction
  function automatic int wcnt(input int d);
    return d == 0 ? wc0 : d == 1 ? wc1 : wc2;
  endfunction
  function automatic logic [DW-1:0] peek(input int d, input int idx);
    return d == 0 ? u0.u_mem.mem[idx] : d == 1 ? u1.u_mem.mem[idx] : u2.u_mem.mem[idx];
  endfunction
  function automatic logic [143:0] wout(input int d);
    return {wst[d], wic[d], wve[d], wvm[d], wde[d], wdm[d]};
  endfunction

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic park(input int d);
    st[d] = S_AOK; ic[d] = I_NOP; ve[d] = '0; va[d] = '0; de[d] = RNONE; dm[d] = RNONE;
    cn[d] = 1'b0; ws[d] = 1'b0; wb[d] = 1'b0;
  endtask

  // one instruction held in M until it leaves; expectations come from cycle counting, not FSM state
  task automatic step(input int d, input logic [3:0] s, input logic [3:0] i, input logic [DW-1:0] e,
                      input logic [DW-1:0] a, input int spct, input logic [15:0] smask, input bit bub);
    logic [DW-1:0] ad, mvx;
    logic [3:0] msx, dex, dmx;
    bit rd, wr, inr, acc, comp, bz, fin;
    int k, w0;
    rd  = i inside {I_MRMOVQ, I_POPQ, I_RET};
    wr  = i inside {I_RMMOVQ, I_PUSHQ, I_CALL};
    ad  = (i == I_POPQ || i == I_RET) ? a : e;
    inr = ad < 64'd256;
    acc = s == S_AOK && (rd || wr) && inr;
    msx = (rd || wr) && !inr ? S_ADR : s;
    dex = 4'($urandom);
    dmx = 4'($urandom);
    @(posedge clk); #1;
    ew[d] = WBUB;
    chk("park_W", wout(d), ew[d]);
    st[d] = s; ic[d] = i; ve[d] = e; va[d] = a; de[d] = dex; dm[d] = dmx;
    cn[d] = 1'($urandom); wb[d] = bub;
    k = 0;
    fin = 0;
    for (int c = 0; c < 40 && !fin; c++) begin
      ws[d] = (c < 16 && smask[c]) || $urandom_range(99) < spct;
      comp = !acc || k == lat(d);
      bz   = acc && k < lat(d);
      mvx  = comp && rd && acc ? mdl[d][ad[AW-1:0]] : '0;
      @(negedge clk);
      chk("mem_busy", busy[d], bz);
      chk("m_stat", ms[d], msx);
      if (!ws[d]) chk("m_valM", mv[d], mvx);
      w0 = wcnt(d);
      @(posedge clk); #1;
      if (!ws[d]) begin
        ew[d] = (bub || bz) ? WBUB : {msx, i, e, mvx, dex, dmx};
        if (comp && wr && acc) mdl[d][ad[AW-1:0]] = a;
        fin = comp;
        k++;
      end
      chk("W_reg", wout(d), ew[d]);
      chk("wr_cnt", wcnt(d) - w0, (!ws[d] && comp && wr && acc) ? 1 : 0);
    end
    chk("completed", fin, 1'b1);
    park(d);
  endtask

  initial begin
    logic [3:0] s, i;
    logic [DW-1:0] e, a;
    for (int d = 0; d < 3; d++) begin
      park(d);
      ew[d] = WBUB;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) chk("reset_W", wout(d), WBUB);
    chk("reset_fsm", u2.state, IDLE);
    rst_n = 1;
    for (int d = 0; d < 3; d++)
      for (int w = 0; w < 256; w++) step(d, S_AOK, I_RMMOVQ, 64'(w), {$urandom, $urandom}, 0, 16'h0, 0);

    step(1, S_AOK, I_RMMOVQ, 64'd8, 64'h1234, 0, 16'h0, 0);
    step(1, S_AOK, I_MRMOVQ, 64'd8, 64'd0, 0, 16'h0, 0);
    chk("lat2_W_valM", wvm[1], 64'h1234);
    chk("lat2_word8", peek(1, 8), 64'h1234);

    step(0, S_AOK, I_PUSHQ, 64'd16, 64'hAA, 0, 16'h0, 0);
    step(0, S_AOK, I_POPQ, 64'd0, 64'd16, 0, 16'h0, 0);
    chk("lat0_W_valM", wvm[0], 64'hAA);

    step(1, S_AOK, I_MRMOVQ, 64'd300, 64'd0, 0, 16'h0, 0);
    chk("adr_W_stat", wst[1], S_ADR);
    chk("adr_mem44", peek(1, 44), mdl[1][44]);

    step(2, S_AOK, I_RMMOVQ, 64'd32, 64'hBEEF, 0, 16'b0011_1000, 0);
    chk("stall_done_word32", peek(2, 32), 64'hBEEF);

    step(1, S_HLT, I_RMMOVQ, 64'd40, 64'h777, 0, 16'h0, 0);
    chk("hlt_W_stat", wst[1], S_HLT);
    chk("hlt_mem40", peek(1, 40), mdl[1][40]);

    @(posedge clk); #1;
    st[2] = S_AOK; ic[2] = I_CALL; ve[2] = 64'd20; va[2] = 64'h5555; de[2] = 4'h4; dm[2] = RNONE;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_busy", busy[2], 1'b1);
    @(negedge clk);
    rst_n = 0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_W", wout(d), WBUB);
      ew[d] = WBUB;
    end
    chk("rst_fsm", u2.state, IDLE);
    park(2);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    chk("post_rst_fsm", u2.state, IDLE);
    chk("rst_mem20", peek(2, 20), mdl[2][20]);

    for (int d = 0; d < 3; d++)
      for (int n = 0; n < 80; n++) begin
        s = $urandom_range(9) < 8 ? S_AOK : 4'(1 << $urandom_range(2));
        i = 4'($urandom_range(11));
        e = $urandom_range(9) == 0 ? {$urandom, $urandom} : 64'($urandom_range(255));
        a = $urandom_range(9) == 0 ? {$urandom, $urandom} : 64'($urandom_range(255));
        step(d, s, i, e, a, 25, 16'h0, $urandom_range(9) == 0);
      end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
